// File: rtl/data_mem_arbiter_if.sv
// Requester-side bus of data_mem_arbiter: one instance per port (CPU LSU, auxiliary master).
// master = requester, slave = arbiter.
interface data_mem_arbiter_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     req;
  logic                     we;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0]    wdata;
  logic [2:0]               funct3;
  logic                     gnt;
  logic                     rsp_valid;
  logic                     rsp_err;
  logic [DATA_WIDTH-1:0]    rdata;

  modport master (
    output req, we, addr, wdata, funct3,
    input  gnt, rsp_valid, rsp_err, rdata
  );

  modport slave (
    input  req, we, addr, wdata, funct3,
    output gnt, rsp_valid, rsp_err, rdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter/sequencer in front of data_mem (IDLE -> ACCESS -> RESP), with range check.
// Define DATA_MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority (port 0 first).
module data_mem_arbiter #(
  parameter int          ADDRESS_WIDTH = 32,
  parameter int          DATA_WIDTH    = 32,
  parameter logic [31:0] MEM_BYTES     = 32'h20000
) (
  input  logic                     clk,
  input  logic                     rst,
  data_mem_arbiter_if.slave        p0,
  data_mem_arbiter_if.slave        p1,
  output logic                     mem_wr_en,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [2:0]               mem_funct3,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                   state;
  logic                     lat_id;
  logic                     lat_we;
  logic                     lat_err;
  logic [ADDRESS_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0]    lat_wdata;
  logic [2:0]               lat_funct3;
  logic                     last_grant;
  logic [1:0]               rsp_valid;
  logic [1:0]               rsp_err;
  logic [DATA_WIDTH-1:0]    rdata [2];

  logic                     win0;
  logic                     win1;
  logic                     p0_first;
  logic                     sel_we;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]    sel_wdata;
  logic [2:0]               sel_funct3;

  // Evaluated one bit wider than the address so an access near the top of the space cannot wrap.
  function automatic logic range_err(input logic [ADDRESS_WIDTH-1:0] addr,
                                     input logic [2:0]               funct3);
    logic [ADDRESS_WIDTH:0] size;
    logic [ADDRESS_WIDTH:0] limit;
    case (funct3[1:0])
      2'b00:   size = (ADDRESS_WIDTH+1)'(1);
      2'b01:   size = (ADDRESS_WIDTH+1)'(2);
      default: size = (ADDRESS_WIDTH+1)'(4);
    endcase
    limit = (ADDRESS_WIDTH+1)'(MEM_BYTES);
    return ({1'b0, addr} + size) > limit;
  endfunction

`ifdef DATA_MEM_ARB_RR_EN
  assign p0_first = last_grant;
`else
  assign p0_first = 1'b1;
`endif

  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    if (state == IDLE && !rst) begin
      if (p0.req && (!p1.req || p0_first)) win0 = 1'b1;
      else if (p1.req)                     win1 = 1'b1;
    end
  end

  assign p0.gnt = win0;
  assign p1.gnt = win1;

  assign sel_we     = win1 ? p1.we     : p0.we;
  assign sel_addr   = win1 ? p1.addr   : p0.addr;
  assign sel_wdata  = win1 ? p1.wdata  : p0.wdata;
  assign sel_funct3 = win1 ? p1.funct3 : p0.funct3;

  // Write strobe is gated by rst so a store caught by reset mid-ACCESS never lands.
  assign mem_wr_en  = (state == ACCESS) && lat_we && !lat_err && !rst;
  assign mem_addr   = lat_addr;
  assign mem_wdata  = lat_wdata;
  assign mem_funct3 = lat_funct3;

  assign p0.rsp_valid = rsp_valid[0];
  assign p0.rsp_err   = rsp_err[0];
  assign p0.rdata     = rdata[0];
  assign p1.rsp_valid = rsp_valid[1];
  assign p1.rsp_err   = rsp_err[1];
  assign p1.rdata     = rdata[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lat_id     <= 1'b0;
      lat_we     <= 1'b0;
      lat_err    <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_funct3 <= '0;
      last_grant <= 1'b1;
      rsp_valid  <= '0;
      rsp_err    <= '0;
      rdata[0]   <= '0;
      rdata[1]   <= '0;
    end else begin
      last_grant <= (win0 || win1) ? win1 : last_grant;
      case (state)
        // IDLE -> ACCESS: latch the winner's payload
        IDLE: begin
          if (win0 || win1) begin
            lat_id     <= win1;
            lat_we     <= sel_we;
            lat_addr   <= sel_addr;
            lat_wdata  <= sel_wdata;
            lat_funct3 <= sel_funct3;
            lat_err    <= range_err(sel_addr, sel_funct3);
            state      <= ACCESS;
          end
        end
        // ACCESS -> RESP: capture read data for the owning port
        ACCESS: begin
          rsp_valid[lat_id] <= 1'b1;
          rsp_err[lat_id]   <= lat_err;
          rdata[lat_id]     <= (!lat_we && !lat_err) ? mem_rdata : '0;
          state             <= RESP;
        end
        // RESP -> IDLE: response lasts exactly one cycle
        RESP: begin
          rsp_valid <= '0;
          rsp_err   <= '0;
          rdata[0]  <= '0;
          rdata[1]  <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
